// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters.
// Hands the winner's word to the master, tracks its cs, and returns ack or err.
module spi_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic                      spi_newd,
  output logic [DATA_W-1:0]         spi_din,
  input  logic                      spi_cs
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LAUNCH, S_XFER, S_DONE, S_ERR
  } state_t;

  state_t           state, next_state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic [CNT_W-1:0] cnt;
  logic             cnt_max;
  logic             cs_meta, cs_s;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[wrap_add(ptr, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr, i);
      end
    end
  end

  assign cnt_max = (cnt == CNT_W'(TIMEOUT));

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (|req) next_state = S_ARB;
      S_ARB:    next_state = win_found ? S_LAUNCH : S_IDLE;
      S_LAUNCH: if (!cs_s) next_state = S_XFER;
                else if (cnt_max) next_state = S_ERR;
      S_XFER:   if (cs_s) next_state = S_DONE;
                else if (cnt_max) next_state = S_ERR;
      S_DONE:   next_state = S_IDLE;
      S_ERR:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // cs comes from the master's sclk domain logic; only cs_s is ever decoded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
    end else begin
      cs_meta <= spi_cs;
      cs_s    <= cs_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      gnt      <= '0;
      spi_din  <= '0;
      spi_newd <= 1'b0;
      cnt      <= '0;
    end else begin
      spi_newd <= (next_state == S_LAUNCH);

      if (next_state != state) cnt <= '0;
      else if ((state == S_LAUNCH || state == S_XFER) && !cnt_max) cnt <= cnt + 1'b1;

      if (state == S_ARB && win_found) begin
        gnt     <= NUM_REQ'(1) << win_idx;
        spi_din <= req_data[win_idx*DATA_W +: DATA_W];
        // Advancing before the outcome is known keeps a stuck requester from starving others.
        ptr     <= wrap_add(win_idx, 1);
      end else if (state == S_DONE || state == S_ERR) begin
        gnt <= '0;
      end
    end
  end

  assign ack  = (state == S_DONE) ? gnt : '0;
  assign err  = (state == S_ERR)  ? gnt : '0;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a behavioural SPI master that
// answers newd by pulling cs low for a fixed frame and logging the word.
module tb_spi_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 12;
  localparam int TIMEOUT = 1023;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        gnt, ack, err;
  logic                      busy, spi_newd;
  logic [DATA_W-1:0]         spi_din;
  logic                      spi_cs = 1'b1;

  spi_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy),
    .spi_newd(spi_newd), .spi_din(spi_din), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          ack_cnt[NUM_REQ];
  int          err_cnt[NUM_REQ];
  int          gnt_log[$];
  logic [11:0] rx_log[$];
  int          viol = 0;
  logic [3:0]  prev_gnt = '0;
  bit          master_en = 1'b1;

  // Behavioural master: latch din on newd, frame for 30 clk, abort on reset.
  logic [11:0] cap;
  bit          aborted;
  always begin
    @(posedge clk); #1;
    if (master_en && rst && spi_newd) begin
      cap = spi_din;
      aborted = 1'b0;
      repeat (4) @(posedge clk);
      #1 spi_cs = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk);
        if (!rst) begin aborted = 1'b1; break; end
      end
      #1 spi_cs = 1'b1;
      if (!aborted) rx_log.push_back(cap);
    end
  end

  always @(negedge clk) begin
    if (!$onehot0(gnt) || !$onehot0(ack) || !$onehot0(err) || ((|ack) && (|err))) viol++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) ack_cnt[i]++;
      if (err[i]) err_cnt[i]++;
      if (gnt[i] && gnt != prev_gnt) gnt_log.push_back(i);
    end
    prev_gnt = gnt;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  task automatic clear_logs();
    for (int i = 0; i < NUM_REQ; i++) begin ack_cnt[i] = 0; err_cnt[i] = 0; end
    gnt_log.delete();
    rx_log.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gnt != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cs_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!spi_cs) begin ok = 1'b1; break; end
    end
  endtask

  // Counts ack/err pulses; drops every request once the target is reached.
  task automatic run_events(input int target, input int budget, output bit ok);
    int got = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((|ack) || (|err)) got++;
      if (got == target) begin req = '0; ok = 1'b1; break; end
    end
    req = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++; if ((ack | err) !== 4'b0) $display("FAIL reset_ack_err: got %b/%b want 0", ack, err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (spi_newd !== 1'b0) $display("FAIL reset_newd: got %b want 0", spi_newd); else n_pass++;
    n_total++; if (spi_din !== 12'h000) $display("FAIL reset_din: got %h want 000", spi_din); else n_pass++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    bit ok, dropped, seen_ack;
    clear_logs();
    req_data[0 +: 12] = 12'hA5C;
    req = 4'b0001;
    wait_gnt(20, ok);
    n_total++; if (!ok) $display("FAIL single_gnt_wait: no grant within 20 cycles"); else n_pass++;
    n_total++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++; if (spi_din !== 12'hA5C) $display("FAIL single_din: got %h want A5C", spi_din); else n_pass++;
    req = 4'b0000;
    dropped = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!spi_newd) dropped = 1'b1;
      if (!spi_cs) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_total++; if (!ok || dropped) $display("FAIL single_newd: cs_seen=%b newd_dropped=%b want 1/0", ok, dropped); else n_pass++;
    seen_ack = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (|ack) begin seen_ack = 1'b1; break; end
    end
    n_total++; if (!seen_ack || ack !== 4'b0001 || busy !== 1'b1) $display("FAIL single_ack: got ack=%b busy=%b want 0001/1", ack, busy); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (rx_log.size() != 1 || rx_log[0] !== 12'hA5C || ack_cnt[0] != 1)
      $display("FAIL single_rx: got %0d words acks=%0d want 1 word A5C, 1 ack", rx_log.size(), ack_cnt[0]); else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    pulse_reset();
    clear_logs();
    req_data[1*12 +: 12] = 12'h111;
    req_data[3*12 +: 12] = 12'h333;
    req = 4'b1010;
    run_events(2, 1000, ok);
    repeat (4) @(negedge clk);
    n_total++; if (!ok) $display("FAIL simul_done: two completions not seen within 1000 cycles"); else n_pass++;
    n_total++; if (gnt_log.size() != 2 || gnt_log[0] != 1 || gnt_log[1] != 3)
      $display("FAIL simul_order: got %0d grants first=%0d want 2 grants 1,3", gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : -1); else n_pass++;
    n_total++; if (ack_cnt[1] != 1 || ack_cnt[3] != 1) $display("FAIL simul_acks: got %0d/%0d want 1/1", ack_cnt[1], ack_cnt[3]); else n_pass++;
    n_total++; if (rx_log.size() != 2 || rx_log[0] !== 12'h111 || rx_log[1] !== 12'h333)
      $display("FAIL simul_rx: got %0d words want 111,333", rx_log.size()); else n_pass++;
  endtask

  task automatic test_fairness();
    bit ok;
    pulse_reset();
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*12 +: 12] = 12'(12'h100 * (i + 1));
    req = 4'b1111;
    run_events(8, 4000, ok);
    repeat (4) @(negedge clk);
    n_total++; if (!ok || gnt_log.size() != 8) $display("FAIL fair_count: got %0d grants want 8", gnt_log.size()); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (k >= gnt_log.size() || gnt_log[k] != k % 4)
        $display("FAIL fair_grant_%0d: got %0d want %0d", k, k < gnt_log.size() ? gnt_log[k] : -1, k % 4);
      else n_pass++;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      n_total++; if (ack_cnt[i] != 2) $display("FAIL fair_ack_%0d: got %0d want 2", i, ack_cnt[i]); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok, seen_err;
    int n;
    clear_logs();
    master_en = 1'b0;
    req_data[2*12 +: 12] = 12'h222;
    req_data[0 +: 12] = 12'h0AA;
    req = 4'b0100;
    wait_gnt(20, ok);
    n_total++; if (!ok || gnt !== 4'b0100 || spi_newd !== 1'b1) $display("FAIL to_gnt: got gnt=%b newd=%b want 0100/1", gnt, spi_newd); else n_pass++;
    req = 4'b0101;
    // First LAUNCH cycle holds count 0; ERR follows the cycle that holds TIMEOUT.
    n = 0;
    seen_err = 1'b0;
    for (int c = 0; c < TIMEOUT + 50; c++) begin
      @(negedge clk);
      n++;
      if (|err) begin seen_err = 1'b1; break; end
    end
    n_total++; if (!seen_err || n != TIMEOUT + 1) $display("FAIL to_latency: got err after %0d cycles (seen=%b) want %0d", n, seen_err, TIMEOUT + 1); else n_pass++;
    n_total++; if (err !== 4'b0100 || ack !== 4'b0000) $display("FAIL to_err: got err=%b ack=%b want 0100/0000", err, ack); else n_pass++;
    master_en = 1'b1;
    @(negedge clk);
    n_total++; if (spi_newd !== 1'b0 || busy !== 1'b0) $display("FAIL to_after: got newd=%b busy=%b want 0/0", spi_newd, busy); else n_pass++;
    run_events(1, 1000, ok);
    repeat (4) @(negedge clk);
    n_total++; if (!ok || gnt_log.size() != 2 || gnt_log[1] != 0)
      $display("FAIL to_next_grant: got %0d grants second=%0d want 2 grants, second 0", gnt_log.size(), gnt_log.size() > 1 ? gnt_log[1] : -1); else n_pass++;
    n_total++; if (ack_cnt[2] != 0 || err_cnt[2] != 1 || ack_cnt[0] != 1)
      $display("FAIL to_counts: got ack2=%0d err2=%0d ack0=%0d want 0/1/1", ack_cnt[2], err_cnt[2], ack_cnt[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_logs();
    req_data[0 +: 12] = 12'h5A1;
    req = 4'b0001;
    wait_cs_low(100, ok);
    repeat (6) @(negedge clk);
    n_total++; if (!ok || busy !== 1'b1 || spi_newd !== 1'b0) $display("FAIL rst_pre: got cs_seen=%b busy=%b newd=%b want 1/1/0", ok, busy, spi_newd); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (gnt !== 4'b0 || busy !== 1'b0 || spi_newd !== 1'b0)
      $display("FAIL rst_async: got gnt=%b busy=%b newd=%b want 0000/0/0", gnt, busy, spi_newd); else n_pass++;
    repeat (3) @(negedge clk);
    req_data[0 +: 12] = 12'h3C7;
    rst = 1'b1;
    n_total++; if (ack_cnt[0] != 0 || err_cnt[0] != 0) $display("FAIL rst_no_pulse: got ack=%0d err=%0d want 0/0", ack_cnt[0], err_cnt[0]); else n_pass++;
    run_events(1, 1000, ok);
    repeat (4) @(negedge clk);
    n_total++; if (!ok || ack_cnt[0] != 1 || rx_log.size() != 1 || rx_log[0] !== 12'h3C7)
      $display("FAIL rst_recover: got acks=%0d words=%0d want 1 ack, 1 word 3C7", ack_cnt[0], rx_log.size()); else n_pass++;
  endtask

  task automatic test_withdraw();
    bit ok;
    clear_logs();
    req_data[0 +: 12] = 12'h0F0;
    req = 4'b0001;
    wait_cs_low(100, ok);
    repeat (6) @(negedge clk);
    req = 4'b0000;
    run_events(1, 200, ok);
    repeat (4) @(negedge clk);
    n_total++; if (!ok || ack_cnt[0] != 1 || err_cnt[0] != 0)
      $display("FAIL withdraw_ack: got ack=%0d err=%0d want 1/0", ack_cnt[0], err_cnt[0]); else n_pass++;
    n_total++; if (rx_log.size() != 1 || rx_log[0] !== 12'h0F0) $display("FAIL withdraw_rx: got %0d words want 1 word 0F0", rx_log.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_reset_mid_frame();
    test_withdraw();
    n_total++; if (viol != 0) $display("FAIL onehot_exclusive: got %0d violations want 0", viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
